// File: rtl/serial_frame_pkg.sv
// serial_frame_pkg: shared definitions for the serial frame receiver.
//   state_e    - receiver FSM state encoding (the spare code 2'd3 falls back to HUNT)
//   DEF_HDR_W  - default header length in bits
//   DEF_HDR    - default header pattern, MSB received first
//   DEF_PL_W   - default payload width
package serial_frame_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        LOAD    = 2'd1,
        PAR     = 2'd2,
        ST_RSVD = 2'd3
    } state_e;

    localparam int         DEF_HDR_W = 4;
    localparam logic [3:0] DEF_HDR   = 4'b0110;
    localparam int         DEF_PL_W  = 6;

endpackage

// File: rtl/serial_frame_rx_hdr_match.sv
// hdr_match: sliding header detector for the serial frame receiver.
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   si   - serial input bit
//   clr  - discard history (held while the receiver is not hunting)
//   hit  - combinational: the current si completes the header
// The detector only reports a match once HDR_W fresh bits have been seen
// since the last clear, so stale payload bits can never form a header.
module hdr_match
    import serial_frame_pkg::*;
#(
    parameter int               HDR_W = DEF_HDR_W,
    parameter logic [HDR_W-1:0] HDR   = HDR_W'(DEF_HDR)
) (
    input  logic clk,
    input  logic rst,
    input  logic si,
    input  logic clr,
    output logic hit
);

    localparam int FW = $clog2(HDR_W);

    logic [HDR_W-2:0] hdr_sr_q;
    logic [FW-1:0]    fill_q;
    logic [HDR_W-1:0] window;
    logic             full;

    assign window = {hdr_sr_q, si};
    assign full   = (fill_q == FW'(HDR_W - 1));
    assign hit    = full && (window == HDR);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            hdr_sr_q <= '0;
            fill_q   <= '0;
        end else begin
            hdr_sr_q <= window[HDR_W-2:0];
            if (!full) fill_q <= fill_q + FW'(1);
        end
    end

endmodule

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: serial frame receiver.
// Hunts for header HDR on si, shifts in PL_W payload bits MSB first and
// optionally checks one trailing even-parity bit.
//   clk       - rising-edge clock
//   rst       - synchronous active-high reset
//   si        - serial input, sampled every rising edge
//   she_pl    - high while payload bits are being shifted
//   valid     - one-cycle pulse on a good frame
//   pl_out    - last good payload, held until the next good frame
//   err       - one-cycle pulse on parity mismatch
//   frame_cnt - good-frame counter, wraps silently
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int               PL_W      = DEF_PL_W,
    parameter int               HDR_W     = DEF_HDR_W,
    parameter logic [HDR_W-1:0] HDR       = HDR_W'(DEF_HDR),
    parameter int               PARITY_EN = 0,
    parameter int               CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             si,
    output logic             she_pl,
    output logic             valid,
    output logic [PL_W-1:0]  pl_out,
    output logic             err,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int BW = $clog2(PL_W);

    state_e           state_q;
    logic [PL_W-1:0]  pl_sr_q;
    logic [BW-1:0]    bit_cnt_q;
    logic             valid_q;
    logic             err_q;
    logic [PL_W-1:0]  pl_out_q;
    logic [CNT_W-1:0] cnt_q;

    logic             hit;
    logic             hm_clr;
    logic [PL_W-1:0]  pl_d;
    logic             last_bit;
    logic             par_ok;

    // History is dropped on the matching edge and for the whole frame body,
    // so hunting restarts from zero fresh bits after every frame.
    assign hm_clr = (state_q != HUNT) || hit;

    hdr_match #(
        .HDR_W (HDR_W),
        .HDR   (HDR)
    ) u_hdr (
        .clk (clk),
        .rst (rst),
        .si  (si),
        .clr (hm_clr),
        .hit (hit)
    );

    assign pl_d     = {pl_sr_q[PL_W-2:0], si};
    assign last_bit = (bit_cnt_q == BW'(PL_W - 1));
    assign par_ok   = ~^{pl_sr_q, si};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= HUNT;
            pl_sr_q   <= '0;
            bit_cnt_q <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            pl_out_q  <= '0;
            cnt_q     <= '0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                HUNT: begin
                    if (hit) begin
                        state_q   <= LOAD;
                        bit_cnt_q <= '0;
                    end
                end
                LOAD: begin
                    pl_sr_q   <= pl_d;
                    bit_cnt_q <= bit_cnt_q + BW'(1);
                    if (last_bit) begin
                        if (PARITY_EN != 0) begin
                            state_q <= PAR;
                        end else begin
                            state_q  <= HUNT;
                            pl_out_q <= pl_d;
                            valid_q  <= 1'b1;
                            cnt_q    <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                PAR: begin
                    state_q <= HUNT;
                    if (par_ok) begin
                        pl_out_q <= pl_sr_q;
                        valid_q  <= 1'b1;
                        cnt_q    <= cnt_q + CNT_W'(1);
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                default: state_q <= HUNT;
            endcase
        end
    end

    assign she_pl    = (state_q == LOAD);
    assign valid     = valid_q;
    assign err       = err_q;
    assign pl_out    = pl_out_q;
    assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: three instances (plain, parity, 2-bit counter)
// share one stimulus stream; a queue-based frame model predicts every output
// every cycle, and directed tables check the documented scenarios.
module tb_serial_frame_rx;

    localparam int         PW   = 6;
    localparam int         HW   = 4;
    localparam logic [3:0] HDRV = 4'b0110;

    logic clk;
    logic rst;
    logic si;

    logic       she0, vld0, err0, she1, vld1, err1, she2, vld2, err2;
    logic [5:0] pl0, pl1, pl2;
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;

    serial_frame_rx dut0 (
        .clk(clk), .rst(rst), .si(si), .she_pl(she0), .valid(vld0),
        .pl_out(pl0), .err(err0), .frame_cnt(cnt0)
    );
    serial_frame_rx #(.PARITY_EN(1)) dut1 (
        .clk(clk), .rst(rst), .si(si), .she_pl(she1), .valid(vld1),
        .pl_out(pl1), .err(err1), .frame_cnt(cnt1)
    );
    serial_frame_rx #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .si(si), .she_pl(she2), .valid(vld2),
        .pl_out(pl2), .err(err2), .frame_cnt(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // reference model state, one per instance
    const int pe[3]   = '{0, 1, 0};
    const int cmod[3] = '{256, 256, 4};
    bit        hq[3][$];
    bit        pq[3][$];
    bit        coll[3];
    logic      m_vld[3];
    logic      m_err[3];
    logic [5:0] m_pl[3];
    int        m_cnt[3];

    // observed tallies
    int nv[3], ne[3], ns[3];
    int cyc_n = 0;
    int vt[$];
    int vc[$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic a_v(int c);
        case (c) 0: return vld0; 1: return vld1; default: return vld2; endcase
    endfunction
    function automatic logic a_e(int c);
        case (c) 0: return err0; 1: return err1; default: return err2; endcase
    endfunction
    function automatic logic a_s(int c);
        case (c) 0: return she0; 1: return she1; default: return she2; endcase
    endfunction
    function automatic logic [31:0] a_pl(int c);
        case (c) 0: return 32'(pl0); 1: return 32'(pl1); default: return 32'(pl2); endcase
    endfunction
    function automatic logic [31:0] a_cnt(int c);
        case (c) 0: return 32'(cnt0); 1: return 32'(cnt1); default: return 32'(cnt2); endcase
    endfunction

    // Frame-level model: remember bits since hunting resumed, then collect the
    // frame body and judge it once all of its bits are in.
    task automatic model_step(int c, bit r, bit s);
        logic [3:0] hv;
        bit         match;
        int         ones;
        logic [5:0] p;
        if (r) begin
            hq[c].delete(); pq[c].delete(); coll[c] = 0;
            m_vld[c] = 0; m_err[c] = 0; m_pl[c] = '0; m_cnt[c] = 0;
            return;
        end
        m_vld[c] = 0; m_err[c] = 0;
        if (!coll[c]) begin
            hq[c].push_back(s);
            if (hq[c].size() > HW) void'(hq[c].pop_front());
            if (hq[c].size() == HW) begin
                hv = HDRV;
                match = 1;
                for (int k = 0; k < HW; k++)
                    if (hq[c][k] != hv[HW-1-k]) match = 0;
                if (match) begin
                    coll[c] = 1; pq[c].delete(); hq[c].delete();
                end
            end
        end else begin
            pq[c].push_back(s);
            if (pq[c].size() == PW + pe[c]) begin
                ones = 0; p = '0;
                for (int k = 0; k < PW; k++) p = {p[4:0], pq[c][k]};
                foreach (pq[c][k]) ones += int'(pq[c][k]);
                if (pe[c] == 0 || ones % 2 == 0) begin
                    m_vld[c] = 1; m_pl[c] = p; m_cnt[c] = (m_cnt[c] + 1) % cmod[c];
                end else begin
                    m_err[c] = 1;
                end
                coll[c] = 0; hq[c].delete(); pq[c].delete();
            end
        end
    endtask

    // drive one cycle, advance the model across the coming edge, compare after it
    task automatic cyc(bit r, bit s);
        rst = r; si = s;
        for (int c = 0; c < 3; c++) model_step(c, r, s);
        @(negedge clk);
        cyc_n++;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("c%0d_valid", c), 32'(a_v(c)), 32'(m_vld[c]));
            chk($sformatf("c%0d_err", c), 32'(a_e(c)), 32'(m_err[c]));
            chk($sformatf("c%0d_she", c), 32'(a_s(c)), 32'(coll[c] && pq[c].size() < PW));
            chk($sformatf("c%0d_pl", c), a_pl(c), 32'(m_pl[c]));
            chk($sformatf("c%0d_cnt", c), a_cnt(c), 32'(m_cnt[c]));
            chk($sformatf("c%0d_excl", c), 32'(a_v(c) & a_e(c)), 32'(0));
            if (a_v(c) === 1'b1) nv[c]++;
            if (a_e(c) === 1'b1) ne[c]++;
            if (a_s(c) === 1'b1) ns[c]++;
            if (c == 2 && a_v(c) === 1'b1) begin
                vt.push_back(cyc_n); vc.push_back(int'(a_cnt(c)));
            end
        end
    endtask

    task automatic clr_tally();
        for (int c = 0; c < 3; c++) begin nv[c] = 0; ne[c] = 0; ns[c] = 0; end
        vt.delete(); vc.delete();
    endtask

    task automatic send(logic [63:0] bits, int nb);
        for (int i = nb - 1; i >= 0; i--) cyc(0, bits[i]);
    endtask

    typedef struct {
        string      name;
        int         cfg;
        int         nb;
        logic [63:0] bits;
        int         ev, ee, es;
        logic [5:0] epl;
        int         ecnt;
    } vec_t;

    vec_t tbl[5];
    int   exp_seq[5];
    logic [5:0] pls[5];

    initial begin
        tbl[0] = '{"basic",    0, 10, 64'b0110_101101,                  1, 0, 6,  6'b101101, 1};
        tbl[1] = '{"slide",    0, 11, 64'b10110_000111,                 1, 0, 6,  6'b000111, 1};
        tbl[2] = '{"pl_hdr",   0, 10, 64'b0110_110110,                  1, 0, 6,  6'b110110, 1};
        tbl[3] = '{"par_good", 1, 11, 64'b0110_101101_0,                1, 0, 6,  6'b101101, 1};
        tbl[4] = '{"par_bad",  1, 22, 64'b0110_101101_0_0110_110000_1,  1, 1, 12, 6'b101101, 1};
        exp_seq = '{1, 2, 3, 0, 1};
        pls     = '{6'b101101, 6'b000111, 6'b110110, 6'b010011, 6'b111111};

        rst = 1'b1; si = 1'b0;
        // reset with random serial input: model expects all zeros
        cyc(1, 1'($urandom_range(0, 1)));
        cyc(1, 1'($urandom_range(0, 1)));

        foreach (tbl[i]) begin
            cyc(1, 0);
            clr_tally();
            send(tbl[i].bits, tbl[i].nb);
            cyc(0, 0); cyc(0, 0);
            chk({tbl[i].name, "_nvalid"}, 32'(nv[tbl[i].cfg]), 32'(tbl[i].ev));
            chk({tbl[i].name, "_nerr"},   32'(ne[tbl[i].cfg]), 32'(tbl[i].ee));
            chk({tbl[i].name, "_nshe"},   32'(ns[tbl[i].cfg]), 32'(tbl[i].es));
            chk({tbl[i].name, "_pl"},     a_pl(tbl[i].cfg),   32'(tbl[i].epl));
            chk({tbl[i].name, "_cnt"},    a_cnt(tbl[i].cfg),  32'(tbl[i].ecnt));
        end

        // reset after three payload bits, then a full frame
        cyc(1, 0);
        clr_tally();
        send(64'b0110_010, 7);
        cyc(1, 1);
        send(64'b0110_010011, 10);
        cyc(0, 0); cyc(0, 0);
        chk("rstmid_nvalid", 32'(nv[0]), 32'(1));
        chk("rstmid_pl", a_pl(0), 32'(6'b010011));
        chk("rstmid_cnt", a_cnt(0), 32'(1));

        // five gapless frames on the 2-bit counter instance
        cyc(1, 0);
        clr_tally();
        for (int f = 0; f < 5; f++) send({54'd0, 4'b0110, pls[f]}, 10);
        cyc(0, 0); cyc(0, 0);
        chk("b2b_nvalid", 32'(vt.size()), 32'(5));
        if (vt.size() == 5) begin
            for (int f = 0; f < 5; f++) begin
                chk($sformatf("b2b_cnt%0d", f), 32'(vc[f]), 32'(exp_seq[f]));
                if (f > 0) chk($sformatf("b2b_gap%0d", f), 32'(vt[f] - vt[f-1]), 32'(10));
            end
        end
        chk("b2b_pl", a_pl(2), 32'(6'b111111));

        // random traffic with injected headers and rare resets
        cyc(1, 0);
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) send(64'b0110, 4);
            else cyc($urandom_range(0, 299) == 0, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
